// File: rtl/mem_block_mover_pkg.sv
// rtl/mem_block_mover_pkg.sv - shared encodings for the block mover
// Purpose: op codes, FSM states and default widths used by mem_block_mover
//          and its datapath.
// Ports:   none (package).
package mem_block_mover_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_MEM_DEPTH = 32;
  localparam int DEF_LEN_W     = 6;
  localparam int DEF_SUM_W     = 14;

  typedef enum logic [1:0] {
    OP_COPY = 2'b00,
    OP_NEG  = 2'b01,
    OP_FILL = 2'b10,
    OP_SUM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

endpackage

// File: rtl/mover_datapath.sv
// rtl/mover_datapath.sv - read-data register, write-data mux and signed accumulator
// Purpose: holds the word read in RD, forms the write data for copy/negate/fill
//          and keeps the running signed sum plus the published sum result.
// Ports:   clock, reset      - clock, async active-high reset
//          cap_en            - capture rd into data register
//          acc_clr, acc_add  - clear / accumulate sign-extended rd
//          sum_load          - publish next accumulator value on sum
//          wr_en, op         - write strobe and latched op, select wd
//          fill_val, rd      - latched fill pattern, memory read data
//          wd, sum           - memory write data, signed sum result
module mover_datapath
  import mem_block_mover_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SUM_W  = DEF_SUM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cap_en,
  input  logic              acc_clr,
  input  logic              acc_add,
  input  logic              sum_load,
  input  logic              wr_en,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] fill_val,
  input  logic [DATA_W-1:0] rd,
  output logic [DATA_W-1:0] wd,
  output logic [SUM_W-1:0]  sum
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SUM_W-1:0]  rd_ext;

  assign rd_ext = {{(SUM_W-DATA_W){rd[DATA_W-1]}}, rd};

  always_comb begin
    data_d = data_q;
    acc_d  = acc_q;
    sum_d  = sum_q;
    if (cap_en) data_d = rd;
    if (acc_clr)      acc_d = '0;
    else if (acc_add) acc_d = acc_q + rd_ext;
    // Publishing the next accumulator value makes sum valid in the same cycle as done.
    if (sum_load) sum_d = acc_d;
  end

  always_comb begin
    wd = '0;
    if (wr_en) begin
      case (op)
        OP_COPY: wd = data_q;
        OP_NEG:  wd = {DATA_W{1'b0}} - data_q;
        OP_FILL: wd = fill_val;
        default: wd = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      acc_q  <= '0;
      sum_q  <= '0;
    end else begin
      data_q <= data_d;
      acc_q  <= acc_d;
      sum_q  <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/mem_block_mover.sv
// rtl/mem_block_mover.sv - block copy/negate/fill/sum engine for the scratch memory
// Purpose: on a start pulse, walks LENGTH consecutive words (addresses wrap
//          modulo MEM_DEPTH) and performs the latched op over them.
// Ports:   clock, reset                  - clock, async active-high reset
//          start, op, src_addr, dst_addr,
//          length, fill_val              - request and its operands (latched at start)
//          busy, done, sum               - status and signed sum result
//          address, wd, read, write, rd  - memory initiator port
module mem_block_mover
  import mem_block_mover_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int SUM_W     = DEF_SUM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wd,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] rd
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [MEM_AW-1:0]   src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d, idx_q, idx_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic                last_word;
  logic                acc_clr;
  logic                unused_addr_bits;

  // Only the in-memory part of the start addresses matters; the rest is dropped.
  assign unused_addr_bits = ^{src_addr[ADDR_W-1:MEM_AW], dst_addr[ADDR_W-1:MEM_AW]};
  assign last_word = (idx_q == len_q - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    acc_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          src_d   = src_addr[MEM_AW-1:0];
          dst_d   = dst_addr[MEM_AW-1:0];
          len_d   = length;
          fill_d  = fill_val;
          idx_d   = '0;
          acc_clr = (op == OP_SUM);
          if (length == '0)      state_d = ST_FIN;
          else if (op == OP_FILL) state_d = ST_WR;
          else                   state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (op_q == OP_SUM) begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = last_word ? ST_FIN : ST_RD;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        idx_d = idx_q + LEN_W'(1);
        if (last_word)            state_d = ST_FIN;
        else if (op_q == OP_FILL) state_d = ST_WR;
        else                      state_d = ST_RD;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port is decoded from registered state only, so it is stable all cycle.
  always_comb begin
    address = '0;
    read    = 1'b0;
    write   = 1'b0;
    if (state_q == ST_RD) begin
      read    = 1'b1;
      address = {{(ADDR_W-MEM_AW){1'b0}}, src_q + idx_q[MEM_AW-1:0]};
    end else if (state_q == ST_WR) begin
      write   = 1'b1;
      address = {{(ADDR_W-MEM_AW){1'b0}}, dst_q + idx_q[MEM_AW-1:0]};
    end
  end

  assign busy = (state_q == ST_RD) || (state_q == ST_WR);
  assign done = (state_q == ST_FIN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
    end
  end

  mover_datapath #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_datapath (
    .clock    (clock),
    .reset    (reset),
    .cap_en   (state_q == ST_RD),
    .acc_clr  (acc_clr),
    .acc_add  ((state_q == ST_RD) && (op_q == OP_SUM)),
    .sum_load ((state_d == ST_FIN) && (op_d == OP_SUM)),
    .wr_en    (write),
    .op       (op_q),
    .fill_val (fill_q),
    .rd       (rd),
    .wd       (wd),
    .sum      (sum)
  );

endmodule
